// File: rtl/fp_norm_pkg.sv
// Shared types and sizing helpers for the FP normaliser pipeline.
// Optional feature macro: FP_NORM_NEG_INPUT_EN (two's-complement significand input).
package fp_norm_pkg;

  localparam int unsigned SIG_W_DEF = 25;
  localparam int unsigned EXP_W_DEF = 8;

  // Width needed to hold a leading-zero count in the range 0..sig_w.
  function automatic int unsigned shift_w(input int unsigned sig_w);
    return $clog2(sig_w + 1);
  endfunction

  localparam int unsigned SHIFT_W_DEF = shift_w(SIG_W_DEF);

  // Stage-1 payload: magnitude, exponent, its leading-zero count and sign.
  typedef struct packed {
    logic [SIG_W_DEF-1:0]   mag;
    logic [EXP_W_DEF-1:0]   exp;
    logic [SHIFT_W_DEF-1:0] lzc;
    logic                   neg;
  } s1_payload_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; result spans 0..SIG_W (SIG_W for all-zero input).
module fp_lzc
  import fp_norm_pkg::*;
#(
  parameter  int unsigned SIG_W = SIG_W_DEF,
  localparam int unsigned CNT_W = shift_w(SIG_W)
) (
  input  logic [SIG_W-1:0] sig_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Scan upward so the highest set bit gives the final count.
  always_comb begin
    cnt_o = CNT_W'(SIG_W);
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (sig_i[i]) cnt_o = CNT_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage valid/ready leading-one normaliser for the FP add/sub datapath.
// Stage 1 registers magnitude, exponent and leading-zero count; stage 2 registers
// the shifted significand, adjusted exponent and zero/denorm flags.
// Optional feature macro: FP_NORM_NEG_INPUT_EN (in_sig is two's complement, out_neg live).
// The stage-1 payload struct is sized by the package defaults for SIG_W/EXP_W.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter  int unsigned SIG_W   = SIG_W_DEF,
  parameter  int unsigned EXP_W   = EXP_W_DEF,
  localparam int unsigned SHIFT_W = shift_w(SIG_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIG_W-1:0]   in_sig,
  input  logic [EXP_W-1:0]   in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIG_W-1:0]   out_sig,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_denorm,
  output logic               out_neg
);

  localparam int unsigned CMP_W = (EXP_W > SHIFT_W) ? EXP_W : SHIFT_W;

  logic               s1_valid_q;
  s1_payload_t        s1_d, s1_q;
  logic               s1_adv, s2_adv;
  logic [SIG_W-1:0]   mag_c;
  logic               neg_c;
  logic [SHIFT_W-1:0] lzc_c;

  logic               out_valid_q;
  logic [SIG_W-1:0]   out_sig_d, out_sig_q;
  logic [EXP_W-1:0]   out_exp_d, out_exp_q;
  logic [SHIFT_W-1:0] out_shift_d, out_shift_q;
  logic               out_zero_d, out_zero_q;
  logic               out_denorm_d, out_denorm_q;
  logic               out_neg_q;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

`ifdef FP_NORM_NEG_INPUT_EN
  assign neg_c = in_sig[SIG_W-1];
  assign mag_c = neg_c ? (~in_sig + SIG_W'(1)) : in_sig;
`else
  assign neg_c = 1'b0;
  assign mag_c = in_sig;
`endif

  fp_lzc #(.SIG_W(SIG_W)) u_lzc (
    .sig_i (mag_c),
    .cnt_o (lzc_c)
  );

  // Assemble the stage-1 payload from the incoming beat.
  always_comb begin
    s1_d     = '0;
    s1_d.mag = mag_c;
    s1_d.exp = in_exp;
    s1_d.lzc = lzc_c;
    s1_d.neg = neg_c;
  end

  // Stage 1 register: accept a beat whenever stage 1 can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Normalise: shift by lzc, clamping to the exponent so it never wraps below zero.
  always_comb begin
    out_sig_d    = '0;
    out_exp_d    = '0;
    out_shift_d  = SHIFT_W'(SIG_W);
    out_zero_d   = 1'b0;
    out_denorm_d = 1'b0;
    if (s1_q.mag == '0) begin
      out_zero_d = 1'b1;
    end else if (CMP_W'(s1_q.lzc) <= CMP_W'(s1_q.exp)) begin
      out_shift_d = s1_q.lzc;
      out_exp_d   = s1_q.exp - EXP_W'(s1_q.lzc);
      out_sig_d   = s1_q.mag << s1_q.lzc;
    end else begin
      out_shift_d  = SHIFT_W'(s1_q.exp);
      out_denorm_d = 1'b1;
      out_sig_d    = s1_q.mag << out_shift_d;
    end
  end

  // Stage 2 register: output fields held while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_sig_q    <= '0;
      out_exp_q    <= '0;
      out_shift_q  <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
      out_neg_q    <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sig_q    <= out_sig_d;
        out_exp_q    <= out_exp_d;
        out_shift_q  <= out_shift_d;
        out_zero_q   <= out_zero_d;
        out_denorm_q <= out_denorm_d;
        out_neg_q    <= s1_q.neg;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sig    = out_sig_q;
  assign out_exp    = out_exp_q;
  assign out_shift  = out_shift_q;
  assign out_zero   = out_zero_q;
  assign out_denorm = out_denorm_q;
  assign out_neg    = out_neg_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (SIG_W=25, EXP_W=8): directed cases,
// back-pressure, mid-stream reset and randomized traffic against a reference model.
module tb_fp_norm_pipe;

  localparam int unsigned SIG_W   = 25;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned SHIFT_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SIG_W-1:0]   in_sig;
  logic [EXP_W-1:0]   in_exp;
  logic               out_valid;
  logic               out_ready;
  logic [SIG_W-1:0]   out_sig;
  logic [EXP_W-1:0]   out_exp;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_zero;
  logic               out_denorm;
  logic               out_neg;

  fp_norm_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sig    (out_sig),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_neg    (out_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIG_W-1:0]   sig;
    logic [EXP_W-1:0]   exp;
    logic [SHIFT_W-1:0] shift;
    logic               zero;
    logic               denorm;
    logic               neg;
  } beat_t;

  beat_t q[$];
  beat_t held;
  logic  held_v;
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: magnitude, bit length, shift = min(leading zeros, exponent).
  function automatic beat_t model(input logic [SIG_W-1:0] s, input logic [EXP_W-1:0] e);
    beat_t  r;
    longint mag, m, bl, lz, sh, ev;
    r.neg = 1'b0;
    mag = longint'(s);
`ifdef FP_NORM_NEG_INPUT_EN
    if (s[SIG_W-1]) begin
      r.neg = 1'b1;
      mag = (longint'(1) <<< SIG_W) - longint'(s);
    end
`endif
    ev = longint'(e);
    if (mag == 0) begin
      r.sig = '0; r.exp = '0; r.shift = SHIFT_W'(SIG_W); r.zero = 1'b1; r.denorm = 1'b0;
    end else begin
      bl = 0; m = mag;
      while (m > 0) begin bl++; m = m >>> 1; end
      lz = longint'(SIG_W) - bl;
      sh = (lz <= ev) ? lz : ev;
      r.sig    = SIG_W'(mag <<< sh);
      r.exp    = EXP_W'(ev - sh);
      r.shift  = SHIFT_W'(sh);
      r.zero   = 1'b0;
      r.denorm = (lz > ev);
    end
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid",  64'(out_valid),  64'(1));
        chk("hold_sig",    64'(out_sig),    64'(held.sig));
        chk("hold_exp",    64'(out_exp),    64'(held.exp));
        chk("hold_shift",  64'(out_shift),  64'(held.shift));
        chk("hold_flags",  64'({out_zero, out_denorm, out_neg}),
                           64'({held.zero, held.denorm, held.neg}));
      end
      held_v      = out_valid && !out_ready;
      held.sig    = out_sig;    held.exp    = out_exp;    held.shift = out_shift;
      held.zero   = out_zero;   held.denorm = out_denorm; held.neg   = out_neg;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("sb_sig",    64'(out_sig),    64'(e.sig));
          chk("sb_exp",    64'(out_exp),    64'(e.exp));
          chk("sb_shift",  64'(out_shift),  64'(e.shift));
          chk("sb_zero",   64'(out_zero),   64'(e.zero));
          chk("sb_denorm", 64'(out_denorm), 64'(e.denorm));
          chk("sb_neg",    64'(out_neg),    64'(e.neg));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_sig, in_exp));
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat with an idle pipe: checks 2-cycle latency and literal expected fields.
  task automatic send_dir(input string tag, input logic [SIG_W-1:0] s, input logic [EXP_W-1:0] e,
                          input logic [SIG_W-1:0] es, input logic [EXP_W-1:0] ee,
                          input logic [SHIFT_W-1:0] esh, input logic ez, input logic ed,
                          input logic en);
    in_sig = s; in_exp = e; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    cycle();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
    cycle();
    chk({tag, "_lat2"},   64'(out_valid),  64'(1));
    chk({tag, "_sig"},    64'(out_sig),    64'(es));
    chk({tag, "_exp"},    64'(out_exp),    64'(ee));
    chk({tag, "_shift"},  64'(out_shift),  64'(esh));
    chk({tag, "_zero"},   64'(out_zero),   64'(ez));
    chk({tag, "_denorm"}, 64'(out_denorm), 64'(ed));
    chk({tag, "_neg"},    64'(out_neg),    64'(en));
    cycle();
  endtask

  initial begin
    logic acc;
    int   rdy_cnt;
    int   sh;
    rst = 1'b1; in_valid = 1'b0; in_sig = '0; in_exp = '0; out_ready = 1'b1; held_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sig",   64'(out_sig),   64'(0));
    chk("rst_out_exp",   64'(out_exp),   64'(0));
    chk("rst_out_shift", 64'(out_shift), 64'(0));
    chk("rst_flags",     64'({out_zero, out_denorm, out_neg}), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b0;
    cycle();

    send_dir("t1_msb",   25'h1000000, 8'd130, 25'h1000000, 8'd130, 5'd0,  1'b0, 1'b0, 1'b0);
    send_dir("t2_lsb",   25'h0000001, 8'd130, 25'h1000000, 8'd106, 5'd24, 1'b0, 1'b0, 1'b0);
    send_dir("t3_zero",  25'h0000000, 8'd77,  25'h0000000, 8'd0,   5'd25, 1'b1, 1'b0, 1'b0);
    send_dir("t4_clamp", 25'h0000100, 8'd10,  25'h0040000, 8'd0,   5'd10, 1'b0, 1'b1, 1'b0);
    send_dir("t_eq",     25'h0000001, 8'd24,  25'h1000000, 8'd0,   5'd24, 1'b0, 1'b0, 1'b0);
    send_dir("t_exp0",   25'h0000001, 8'd0,   25'h0000001, 8'd0,   5'd0,  1'b0, 1'b1, 1'b0);
`ifdef FP_NORM_NEG_INPUT_EN
    send_dir("t6_neg",   25'h1FFFFFF, 8'd100, 25'h1000000, 8'd76,  5'd24, 1'b0, 1'b0, 1'b1);
    send_dir("t_mostneg",25'h1000000, 8'd50,  25'h1000000, 8'd50,  5'd0,  1'b0, 1'b0, 1'b1);
`else
    send_dir("t6_neg",   25'h1FFFFFF, 8'd100, 25'h1FFFFFF, 8'd100, 5'd0,  1'b0, 1'b0, 1'b0);
`endif

    // Back-pressure: three back-to-back beats while downstream stalls for 4 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sig = 25'h0000003; in_exp = 8'd40;
    cycle();
    in_sig = 25'h0000000; in_exp = 8'd9;
    cycle();
    in_sig = 25'h0000800; in_exp = 8'd5;
    chk("bp_in_ready_drop", 64'(in_ready), 64'(0));
    cycle();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc = in_ready;
      cycle();
      if (acc) begin in_valid = 1'b0; break; end
    end
    chk("bp_third_taken", 64'(in_valid), 64'(0));
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    chk("bp_drain", 64'(q.size()), 64'(0));

    // Full throughput: in_ready stays high with out_ready held at 1.
    rdy_cnt = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sig = SIG_W'($urandom); in_exp = EXP_W'($urandom);
      if (in_ready) rdy_cnt++;
      cycle();
    end
    in_valid = 1'b0;
    chk("tput_ready", 64'(rdy_cnt), 64'(10));
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    chk("tput_drain", 64'(q.size()), 64'(0));

    // Reset while beats are in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_sig = 25'h0001234; in_exp = 8'd200;
    cycle();
    cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete(); held_v = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready",  64'(in_ready),  64'(1));
    out_ready = 1'b1;
    cycle();
    chk("midrst_no_ghost", 64'(out_valid), 64'(0));

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sh        = int'($urandom_range(0, SIG_W));
      in_sig    = SIG_W'($urandom) >> sh;
      in_exp    = ($urandom_range(0, 1) != 0) ? EXP_W'($urandom_range(0, 30)) : EXP_W'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    chk("rand_drain", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
Parametrised, pipelined leading-one normaliser for the FP add/sub datapath. It replaces the combinational casex normaliser.
- Takes a raw significand plus an exponent.
- Left-shifts the significand until its MSB is 1 and reduces the exponent by the shift amount.
- Clamps the shift when the exponent would underflow, and flags zero and denormal results.
- Two-stage valid/ready pipeline sitting between the significand adder and the rounding stage.

Parameters:
SIG_W, 25, significand width in bits (carry bit included)
EXP_W, 8, exponent width in bits
SHIFT_W, $clog2(SIG_W+1), width of the shift count; derived, never overridden

Ports:
clk  input  1  clock; all logic is rising-edge triggered
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
in_sig  input  SIG_W  raw significand
in_exp  input  EXP_W  exponent before normalisation
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out_sig  output  SIG_W  normalised significand
out_exp  output  EXP_W  adjusted exponent
out_shift  output  SHIFT_W  applied left-shift amount
out_zero  output  1  magnitude was zero
out_denorm  output  1  shift was clamped by the exponent
out_neg  output  1  input was negative (NEG_INPUT_EN only; otherwise 0)

Behaviour:
- Reset (rst=1 at a clk edge):
  - Both stage valid flags clear, so out_valid=0.
  - All output data registers clear to 0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards any in-flight beats.
- Handshake:
  - A transfer occurs when valid and ready are both high at a clk edge.
  - out_* fields are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - in_ready must not depend combinationally on in_valid.
- Pipeline control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Full throughput (one beat per cycle) when out_ready is held at 1.
  - Latency is 2 cycles from input transfer to out_valid.
- Stage 1 (registered):
  - Latch mag = in_sig (see the optional feature for negative inputs).
  - Latch in_exp.
  - Compute lzc = number of leading zeros of mag, range 0..SIG_W.
- Stage 2 (registered):
  - mag==0: out_sig=0, out_exp=0, out_shift=SIG_W, out_zero=1, out_denorm=0.
  - lzc <= exp: shift=lzc, out_exp=exp-lzc, out_denorm=0.
  - lzc > exp: shift=exp (clamped), out_exp=0, out_denorm=1.
  - Non-zero cases: out_sig = mag << shift, truncated to SIG_W bits; out_shift = shift.
- Width rules:
  - The exponent subtraction is unsigned EXP_W bits and never wraps, because of the clamp.
  - The shift compare zero-extends lzc to max(EXP_W, SHIFT_W).
- Simultaneous events: an input and an output transfer in the same cycle are both honoured, and no bubble is inserted.

Optional Feature:
- Macro: FP_NORM_NEG_INPUT_EN
- Defined:
  - in_sig is treated as two's complement.
  - If in_sig[SIG_W-1]=1: mag = ~in_sig + 1 (SIG_W-bit unsigned result) and out_neg=1 for that beat.
  - out_neg is pipelined alongside the data.
  - Most-negative input 1<<(SIG_W-1) gives mag = 1<<(SIG_W-1).
- Undefined:
  - in_sig is unsigned magnitude.
  - out_neg is tied to 0.
  - No negation logic is built.

Decomposition:
- Package fp_norm_pkg:
  - Default SIG_W/EXP_W localparams.
  - A clog2-based SHIFT_W helper.
  - Packed struct type for the stage-1 payload (mag, exp, lzc, neg).
- Sub-module fp_lzc:
  - Purely combinational leading-zero counter, parametrised by SIG_W.
  - Outputs count 0..SIG_W; reused later by the multiplier path.

Test Plan (SIG_W=25, EXP_W=8):
1. in_sig=25'h1000000, in_exp=130 -> out_sig=25'h1000000, out_exp=130, out_shift=0, zero=0, denorm=0, 2 cycles later.
2. in_sig=25'h0000001, in_exp=130 -> out_sig=25'h1000000, out_exp=106, out_shift=24.
3. in_sig=0, in_exp=77 -> out_sig=0, out_exp=0, out_shift=25, out_zero=1.
4. Clamp case: in_sig=25'h0000100 (lzc=16), in_exp=10 -> out_sig=25'h0040000, out_exp=0, out_shift=10, out_denorm=1.
5. Back-pressure: three back-to-back beats with out_ready=0 for 4 cycles.
   - in_ready drops after two beats are accepted.
   - out_* stays stable throughout.
   - After out_ready=1, all three beats emerge in order with no loss or duplication.
   - rst asserted mid-stream -> out_valid=0 on the next cycle.
6. With FP_NORM_NEG_INPUT_EN: in_sig=25'h1FFFFFF, in_exp=100 -> out_neg=1, out_sig=25'h1000000, out_exp=76, out_shift=24. Without the macro, the same input gives out_neg=0, out_shift=0, out_exp=100.
